// File: rtl/uart_receiver.sv
// Oversampling UART receiver: 8N1 or 8+parity frames, sampled mid-bit on ticks
// taken from the rising edges of the baud generator's oversample clock.
module uart_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_rx,
  input  logic [7:0]            prescale,
  input  logic                  rx_serial,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta_q, rx_meta_d;
  logic                    rxs_q, rxs_d;
  logic                    baud_q, baud_d;
  logic [7:0]              tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]              pre_l_q, pre_l_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    parity_err_q, parity_err_d;
  logic                    frame_err_q, frame_err_d;
  logic                    tick;
  logic [7:0]              cnt_inc;
  logic                    bit_done;

  assign tick     = baud_rx & ~baud_q;
  assign cnt_inc  = tick_cnt_q + 8'd1;
  assign bit_done = tick && (cnt_inc == pre_l_q);

  always_comb begin
    state_d      = state_q;
    rx_meta_d    = rx_serial;
    rxs_d        = rx_meta_q;
    baud_d       = baud_rx;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    pre_l_d      = pre_l_q;
    shift_d      = shift_q;
    par_d        = par_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A prescale below 2 cannot place a mid-bit sample, so the line is ignored.
        if (!rxs_q && (prescale >= 8'd2)) begin
          state_d    = START;
          tick_cnt_d = 8'd0;
          pre_l_d    = prescale;
        end
      end
      START: begin
        if (tick) begin
          tick_cnt_d = cnt_inc;
          if (cnt_inc == {1'b0, pre_l_q[7:1]}) begin
            tick_cnt_d = 8'd0;
            bit_cnt_d  = '0;
            state_d    = rxs_q ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (tick) tick_cnt_d = cnt_inc;
        if (bit_done) begin
          shift_d[bit_cnt_q] = rxs_q;
          tick_cnt_d         = 8'd0;
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) tick_cnt_d = cnt_inc;
        if (bit_done) begin
          par_d      = rxs_q;
          tick_cnt_d = 8'd0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (tick) tick_cnt_d = cnt_inc;
        if (bit_done) begin
          tick_cnt_d = 8'd0;
          rx_data_d  = shift_q;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end else if (PARITY_EN && ((^shift_q) ^ par_q ^ PARITY_ODD)) begin
            parity_err_d = 1'b1;
            state_d      = IDLE;
          end else begin
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line recovers so a break is not read as a new start bit.
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      baud_q       <= 1'b0;
      tick_cnt_q   <= 8'd0;
      bit_cnt_q    <= '0;
      pre_l_q      <= 8'd0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rxs_q        <= rxs_d;
      baud_q       <= baud_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      pre_l_q      <= pre_l_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Oversampling UART receiver for the serial path. It consumes the `rx` oversample clock from the baud rate generator as a level signal and detects its rising edges in the `clk` domain. It recovers 8N1 or 8-bit-plus-parity frames from the serial line and presents each byte with a one-cycle valid strobe and error flags to the downstream consumer.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, LSB first.
- `PARITY_EN`, 0: 1 means one parity bit follows the data bits.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even. Ignored when `PARITY_EN`=0.
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `baud_rx` in 1: oversample clock level from the baud generator. Each rising edge, seen in `clk` domain, is one tick.
- `prescale` in 8: ticks per bit. Legal range 2..255. Latched at start-bit detection.
- `rx_serial` in 1: asynchronous serial line, idle high.
- `rx_data` out DATA_WIDTH: last received data. Holds until the next frame ends.
- `rx_valid` out 1: one-cycle pulse for a good frame.
- `parity_err` out 1: one-cycle pulse when the stop bit is good but parity fails.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `busy` out 1: high in every state except IDLE.

## Operation
- **Input conditioning**
  - `rx_serial` passes through a 2-flop synchronizer, reset value 1. Its output is `rxs`.
  - `baud_rx` is registered once. `tick = baud_rx & ~baud_rx_q`.
- **Counters**
  - Tick counter is 8 bits and counts ticks only.
  - Bit counter is sized for DATA_WIDTH.
  - `pre_l` holds `prescale`, latched on the IDLE->START transition.
- **States**
  - IDLE
    - `rxs`==0 causes a transition to START and clears the tick counter.
    - If `prescale` < 2, the block stays in IDLE and ignores the line.
  - START
    - When the tick counter reaches `pre_l>>1` on a tick, sample `rxs`.
    - Sample 0: go to DATA and clear the counters.
    - Sample 1: treat as a glitch and return to IDLE. No output pulse.
  - DATA
    - On the tick where the counter reaches `pre_l`, sample `rxs` into the shift register at bit index `bitcnt` (LSB first) and clear the tick counter.
    - After DATA_WIDTH samples, go to PARITY if `PARITY_EN`, else to STOP.
  - PARITY: sample after `pre_l` ticks and store the received parity bit.
  - STOP: sample after `pre_l` ticks, then resolve the outcome with this priority:
    1. Stop bit 0: `frame_err` pulses. Go to WAIT_IDLE.
    2. Parity mismatch (XOR of data ^ parity bit ^ `PARITY_ODD` is nonzero): `parity_err` pulses. Go to IDLE.
    3. Otherwise `rx_valid` pulses. Go to IDLE.
  - In all three outcomes `rx_data` is loaded from the shift register.
  - WAIT_IDLE: stays here until `rxs`==1, then goes to IDLE. This prevents retriggering on a break condition.
- Outcome pulses are mutually exclusive and never overlap.
- Changing `prescale` mid-frame has no effect until the next start bit.
- Ticks arriving while in IDLE or WAIT_IDLE are ignored.

## Timing
- **Reset values:** state=IDLE, `rx_data`=0, `rx_valid`=`parity_err`=`frame_err`=`busy`=0, synchronizer=1, counters=0.
- Reset asserted mid-frame aborts the frame immediately with no pulse. After release the block waits for a new falling edge.
- Line-to-detection latency is 2 `clk` cycles (synchronizer), plus 1 cycle to enter START.
- Outcome pulses are registered. They appear on the `clk` cycle after the stop-sample tick and last exactly 1 cycle.
- `rx_data` changes on the same edge that the pulse rises.
- `busy` falls on the same edge that the pulse rises, or on leaving WAIT_IDLE.
- **Back-to-back frames:** a start bit immediately following the stop bit is detected. IDLE is reached one cycle after the stop-sample tick, which is well inside the second half of the stop bit.

## Test plan
- **Good frame:** `prescale`=16, `PARITY_EN`=0, send 0xA5 at 16 ticks/bit. Expect `rx_valid` for 1 cycle, `rx_data`=0xA5, no error pulses, `busy` low afterwards.
- **Start glitch:** drive `rx_serial` low for 3 ticks, then high, with `prescale`=16. Expect return to IDLE, no pulses, `rx_data` unchanged. A following 0x3C frame is received correctly.
- **Framing error:** send 0x55 with the stop bit held low, then keep the line low for 40 ticks. Expect `frame_err` for 1 cycle, `rx_data`=0x55, `busy` high until the line returns high, and no spurious second frame.
- **Parity:** `PARITY_EN`=1, `PARITY_ODD`=0.
  - Send 0x81 with parity bit 0: expect `rx_valid`.
  - Send 0x81 with parity bit 1: expect `parity_err` only, `rx_data`=0x81.
- **Reset mid-frame:** assert `rst` during data bit 4 of a 0xF0 frame. Expect all outputs 0 and state IDLE. After release a 0x0F frame yields `rx_valid` with `rx_data`=0x0F.
- **Back-to-back frames and prescale change:** send 0x12 then 0x34 with zero idle gap, `prescale`=8. Change `prescale` to 4 mid-0x12 and transmit 0x34 at 4 ticks/bit. Expect two `rx_valid` pulses with 0x12 then 0x34.
